tick_rate_controller: RTL and testbench

TICK_RATE_CONTROLLER -- requirements
Module: tick_rate_controller

---
 rtl/tick_rate_controller_if.sv | 24 ++
 rtl/tick_rate_controller.sv | 120 ++++++++++++
 tb/tb_tick_rate_controller.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/tick_rate_controller_if.sv
// Signal bundle between a mode requester and tick_rate_controller.
// Handshake: mode_req/mode_req_valid are sampled on a rising clk_in edge only while busy is low
// (busy is the inverted ready); a request offered while busy is high is dropped, never queued.
interface tick_rate_controller_if;
  logic [1:0] mode_req;
  logic       mode_req_valid;
  logic       pause;
  logic       busy;
  logic       mode_ack;
  logic [1:0] mode_cur;
  logic       tick_o;
  logic       scan_tick_o;
  logic [1:0] dbg_state;

  modport master (
    output mode_req, mode_req_valid, pause,
    input  busy, mode_ack, mode_cur, tick_o, scan_tick_o, dbg_state
  );

  modport slave (
    input  mode_req, mode_req_valid, pause,
    output busy, mode_ack, mode_cur, tick_o, scan_tick_o, dbg_state
  );
endinterface

// File: rtl/tick_rate_controller.sv
// Mode-selectable main tick divider with a free-running display-scan divider.
// Mode changes wait for the current period to wrap so the tick rate never changes mid-period.
module tick_rate_controller #(
  parameter int unsigned DIV_NORMAL = 100000000,
  parameter int unsigned DIV_FAST   = 1000000,
  parameter int unsigned DIV_SET    = 25000000,
  parameter int unsigned DIV_SCAN   = 100000
) (
  input  logic                   clk_in,
  input  logic                   rst_n,
  tick_rate_controller_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    PENDING = 2'd1,
    APPLY   = 2'd2
  } state_t;

  localparam logic [1:0]  MODE_STOP = 2'd3;
  localparam logic [31:0] SCAN_LAST = DIV_SCAN - 32'd1;

  state_t      state_q, state_d;
  logic [1:0]  mode_q;
  logic [1:0]  latch_q, latch_d;
  logic        ack_q, ack_d;
  logic [31:0] cnt_q;
  logic [31:0] scan_q;
  logic [31:0] div_sel;
  logic        run_en;
  logic        tick;
  logic        scan_tick;

  // Divider depends only on the applied mode, never on a pending request.
  always_comb begin
    div_sel = DIV_NORMAL;
    case (mode_q)
      2'd1:    div_sel = DIV_FAST;
      2'd2:    div_sel = DIV_SET;
      default: div_sel = DIV_NORMAL;
    endcase
  end

  assign run_en    = (state_q != APPLY) && (mode_q != MODE_STOP) && !bus.pause;
  assign tick      = run_en && (cnt_q == div_sel - 32'd1);
  assign scan_tick = (scan_q == SCAN_LAST);

  always_comb begin
    state_d = state_q;
    latch_d = latch_q;
    ack_d   = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.mode_req_valid) begin
          if (bus.mode_req != mode_q) begin
            latch_d = bus.mode_req;
            state_d = PENDING;
          end else begin
            ack_d = 1'b1;
          end
        end
      end
      PENDING: begin
        // Counter is frozen when stopped or paused, so waiting for a wrap would stall forever.
        if (tick || (mode_q == MODE_STOP) || bus.pause) begin
          state_d = APPLY;
        end
      end
      APPLY: begin
        state_d = RUN;
        ack_d   = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      latch_q <= 2'd0;
      ack_q   <= 1'b0;
      mode_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      latch_q <= latch_d;
      ack_q   <= ack_d;
      if (state_q == APPLY) begin
        mode_q <= latch_q;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 32'd0;
    end else if ((state_q == APPLY) || (mode_q == MODE_STOP) || tick) begin
      cnt_q <= 32'd0;
    end else if (run_en) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      scan_q <= 32'd0;
    end else if (scan_tick) begin
      scan_q <= 32'd0;
    end else begin
      scan_q <= scan_q + 32'd1;
    end
  end

  assign bus.busy        = (state_q != RUN);
  assign bus.mode_ack    = ack_q;
  assign bus.mode_cur    = mode_q;
  assign bus.tick_o      = tick;
  assign bus.scan_tick_o = scan_tick;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_tick_rate_controller.sv
// Bench for tick_rate_controller: directed table and scenarios plus random traffic
// checked every cycle against a cycle-level behavioural model of the mode/tick rules.
module tb_tick_rate_controller;

  localparam int DIV_NORMAL = 10;
  localparam int DIV_FAST   = 4;
  localparam int DIV_SET    = 6;
  localparam int DIV_SCAN   = 3;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b1;
  always #5 clk_in = ~clk_in;

  tick_rate_controller_if bus ();

  tick_rate_controller #(
    .DIV_NORMAL (DIV_NORMAL),
    .DIV_FAST   (DIV_FAST),
    .DIV_SET    (DIV_SET),
    .DIV_SCAN   (DIV_SCAN)
  ) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic       s_tick, s_scan, s_busy, s_ack;
  logic [1:0] s_mode;

  // Model: applied mode, phase within the period, cycles since reset, pending target.
  int m_mode, m_phase, m_t, m_target;
  bit m_pend, m_apply, m_ack;

  typedef struct {
    logic       p;
    logic       v;
    logic [1:0] r;
    logic       tick;
    logic       scan;
    logic       busy;
    logic       ack;
    logic [1:0] mode;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(int p, int v, int r, int tk, int sc, int bz, int ak, int md);
    vec_t x;
    x.p = p[0]; x.v = v[0]; x.r = r[1:0];
    x.tick = tk[0]; x.scan = sc[0]; x.busy = bz[0]; x.ack = ak[0]; x.mode = md[1:0];
    return x;
  endfunction

  function automatic int div_of(int m);
    case (m)
      1:       return DIV_FAST;
      2:       return DIV_SET;
      default: return DIV_NORMAL;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0d: got %0d, expected %0d", name, m_t, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_phase = 0; m_t = 0; m_target = 0;
    m_pend = 0; m_apply = 0; m_ack = 0;
  endtask

  // Entered at posedge+1; drives inputs, samples at negedge, returns at next posedge+1.
  task automatic cycle(input logic p, input logic v, input logic [1:0] r);
    int d;
    bit e_tick;
    bus.pause = p; bus.mode_req_valid = v; bus.mode_req = r;
    @(negedge clk_in);
    s_tick = bus.tick_o; s_scan = bus.scan_tick_o; s_busy = bus.busy;
    s_ack = bus.mode_ack; s_mode = bus.mode_cur;
    d = div_of(m_mode);
    e_tick = !m_apply && (m_mode != 3) && !p && (m_phase == d - 1);
    check("model_tick", s_tick, e_tick);
    check("model_scan", s_scan, ((m_t + 1) % DIV_SCAN) == 0);
    check("model_busy", s_busy, m_pend || m_apply);
    check("model_ack", s_ack, m_ack);
    check("model_mode", s_mode, m_mode);
    m_ack = 0;
    if (m_apply) begin
      m_mode = m_target; m_phase = 0; m_apply = 0; m_ack = 1;
    end else begin
      if (m_mode == 3) m_phase = 0;
      else if (!p) m_phase = (m_phase + 1) % d;
      if (m_pend) begin
        if (e_tick || m_mode == 3 || p) begin m_pend = 0; m_apply = 1; end
      end else if (v) begin
        if (int'(r) != m_mode) begin m_pend = 1; m_target = r; end
        else m_ack = 1;
      end
    end
    m_t++;
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.pause = 1'b0; bus.mode_req_valid = 1'b0; bus.mode_req = 2'd0;
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_ack", bus.mode_ack, 0);
    check("rst_mode", bus.mode_cur, 0);
    check("rst_tick", bus.tick_o, 0);
    check("rst_scan", bus.scan_tick_o, 0);
    repeat (2) @(posedge clk_in);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // t: pause valid req | tick scan busy ack mode  (mode 0 -> 1 requested at counter 2)
    tbl[0]  = mk(0,0,0, 0,0,0,0,0);  tbl[1]  = mk(0,0,0, 0,0,0,0,0);
    tbl[2]  = mk(0,1,1, 0,1,0,0,0);  tbl[3]  = mk(0,0,0, 0,0,1,0,0);
    tbl[4]  = mk(0,0,0, 0,0,1,0,0);  tbl[5]  = mk(0,0,0, 0,1,1,0,0);
    tbl[6]  = mk(0,0,0, 0,0,1,0,0);  tbl[7]  = mk(0,0,0, 0,0,1,0,0);
    tbl[8]  = mk(0,0,0, 0,1,1,0,0);  tbl[9]  = mk(0,0,0, 1,0,1,0,0);
    tbl[10] = mk(0,0,0, 0,0,1,0,0);  tbl[11] = mk(0,0,0, 0,1,0,1,1);
    tbl[12] = mk(0,0,0, 0,0,0,0,1);  tbl[13] = mk(0,0,0, 0,0,0,0,1);
    tbl[14] = mk(0,0,0, 1,1,0,0,1);  tbl[15] = mk(0,0,0, 0,0,0,0,1);
    tbl[16] = mk(0,0,0, 0,0,0,0,1);  tbl[17] = mk(0,0,0, 0,1,0,0,1);
    tbl[18] = mk(0,0,0, 1,0,0,0,1);

    #2;
    // Free run after reset: ticks every 10, scan every 3.
    do_reset();
    for (int t = 0; t < 40; t++) begin
      cycle(1'b0, 1'b0, 2'd0);
      check("a_tick", s_tick, (t % 10) == 9);
      check("a_scan", s_scan, (t % 3) == 2);
      check("a_mode", s_mode, 0);
    end

    // Table: mode 0 -> 1 at the wrap.
    do_reset();
    for (int i = 0; i < 19; i++) begin
      cycle(tbl[i].p, tbl[i].v, tbl[i].r);
      check("b_tick", s_tick, tbl[i].tick);
      check("b_scan", s_scan, tbl[i].scan);
      check("b_busy", s_busy, tbl[i].busy);
      check("b_ack", s_ack, tbl[i].ack);
      check("b_mode", s_mode, tbl[i].mode);
    end

    // Reset while a mode 1 -> 2 change is pending discards it.
    cycle(1'b0, 1'b1, 2'd2);
    check("f_mode_before", s_mode, 1);
    cycle(1'b0, 1'b0, 2'd0);
    check("f_busy_pending", s_busy, 1);
    do_reset();
    for (int t = 0; t < 15; t++) begin
      cycle(1'b0, 1'b0, 2'd0);
      check("f_ack", s_ack, 0);
      check("f_busy", s_busy, 0);
      check("f_mode", s_mode, 0);
      check("f_tick", s_tick, t == 9);
    end

    // Pause for 7 cycles while the counter holds 5.
    do_reset();
    for (int t = 0; t < 20; t++) begin
      cycle((t >= 5) && (t <= 11), 1'b0, 2'd0);
      check("c_tick", s_tick, t == 16);
      check("c_scan", s_scan, (t % 3) == 2);
    end

    // Stop request, ignored request while busy, then immediate set-mode apply from stop.
    do_reset();
    for (int t = 0; t < 37; t++) begin
      if (t == 2)                 cycle(1'b0, 1'b1, 2'd3);
      else if (t == 4 || t == 21) cycle(1'b0, 1'b1, 2'd2);
      else                        cycle(1'b0, 1'b0, 2'd0);
      check("d_tick", s_tick, (t == 9) || (t == 29) || (t == 35));
      check("d_busy", s_busy, ((t >= 3) && (t <= 10)) || (t == 22) || (t == 23));
      check("d_ack", s_ack, (t == 11) || (t == 24));
      check("d_mode", s_mode, (t <= 10) ? 0 : ((t <= 23) ? 3 : 2));
    end

    // Same-mode request: ack only, phase undisturbed.
    do_reset();
    for (int t = 0; t < 21; t++) begin
      cycle(1'b0, (t == 4), 2'd0);
      check("e_ack", s_ack, t == 5);
      check("e_busy", s_busy, 0);
      check("e_tick", s_tick, (t == 9) || (t == 19));
    end

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, 2'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
